conv_engine: RTL and testbench

//  Parametrised single-layer convolution engine: K x K x CHIN window, any STRIDE, zero PAD

---
 rtl/conv_pkg.sv | 40 ++++
 rtl/conv_engine_if.sv | 32 +++
 rtl/conv_addr_gen.sv | 124 ++++++++++++
 rtl/conv_engine.sv | 186 ++++++++++++++++++
 tb/tb_conv_engine.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution engine: FSM states, width helpers
// and the requantisation clamp applied to every output lane.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT,
    DONE
  } state_e;

  // Widest requantised word sat_relu can return; WIDTH must not exceed this.
  localparam int MAX_OUT_W = 32;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int out_dim(input int n, input int k, input int stride, input int pad);
    return (n + 2 * pad - k) / stride + 1;
  endfunction

  // Optional ReLU followed by saturation to a signed word of the given width.
  function automatic logic signed [MAX_OUT_W-1:0] sat_relu(input logic signed [63:0] val,
                                                           input int width,
                                                           input logic relu);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] v;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    v  = val;
    if (relu && (v < 0)) v = '0;
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v[MAX_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/conv_engine_if.sv
// Memory-side and output-stream signals of the convolution engine, bundled so the
// engine and its environment agree on widths in one place.
interface conv_engine_if #(
  parameter int WIDTH = 16,
  parameter int CHOUT = 64,
  parameter int AW    = 18,
  parameter int WAW   = 5,
  parameter int RW    = 7,
  parameter int CW    = 7
);
  logic                               ifm_rd;
  logic [AW-1:0]                      ifm_addr;
  logic [WIDTH-1:0]                   ifm_data;
  logic [WAW-1:0]                     w_addr;
  logic [CHOUT-1:0][WIDTH-1:0]        w_data;
  logic [CHOUT-1:0][2*WIDTH-1:0]      bias;
  logic                               ofm_valid;
  logic                               ofm_ready;
  logic [CHOUT-1:0][WIDTH-1:0]        ofm;
  logic [RW-1:0]                      ofm_row;
  logic [CW-1:0]                      ofm_col;

  modport master (
    output ifm_rd, ifm_addr, w_addr, ofm_valid, ofm, ofm_row, ofm_col,
    input  ifm_data, w_data, bias, ofm_ready
  );

  modport slave (
    input  ifm_rd, ifm_addr, w_addr, ofm_valid, ofm, ofm_row, ofm_col,
    output ifm_data, w_data, bias, ofm_ready
  );
endinterface

// File: rtl/conv_addr_gen.sv
// Window and tap counters for the convolution engine; turns the current tap into an
// IFM address, weight index and zero-pad flag.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int H_IN   = 256,
  parameter int W_IN   = 256,
  parameter int CHIN   = 3,
  parameter int K      = 3,
  parameter int STRIDE = 2,
  parameter int PAD    = 1,
  localparam int TAPS  = K * K * CHIN,
  localparam int H_OUT = out_dim(H_IN, K, STRIDE, PAD),
  localparam int W_OUT = out_dim(W_IN, K, STRIDE, PAD),
  localparam int AW    = cw(H_IN * W_IN * CHIN),
  localparam int WAW   = cw(TAPS),
  localparam int RW    = cw(H_OUT),
  localparam int CW    = cw(W_OUT)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           tap_en,
  input  logic           win_en,
  output logic           ifm_rd,
  output logic [AW-1:0]  ifm_addr,
  output logic [WAW-1:0] w_addr,
  output logic           pad,
  output logic           last_tap,
  output logic           last_window,
  output logic [RW-1:0]  oy,
  output logic [CW-1:0]  ox
);

  localparam int KW  = cw(K);
  localparam int CHW = cw(CHIN);

  logic [CHW-1:0] c_q, c_d;
  logic [KW-1:0]  ky_q, ky_d, kx_q, kx_d;
  logic [WAW-1:0] tap_q, tap_d;
  logic [RW-1:0]  oy_q, oy_d;
  logic [CW-1:0]  ox_q, ox_d;

  int  y_i, x_i, addr_i;
  logic in_bounds;

  assign last_tap    = (tap_q == WAW'(TAPS - 1));
  assign last_window = (oy_q == RW'(H_OUT - 1)) && (ox_q == CW'(W_OUT - 1));

  // Taps run kx fastest, then ky, then channel; windows run column fastest.
  always_comb begin
    c_d   = c_q;
    ky_d  = ky_q;
    kx_d  = kx_q;
    tap_d = tap_q;
    oy_d  = oy_q;
    ox_d  = ox_q;
    if (clear) begin
      c_d   = '0;
      ky_d  = '0;
      kx_d  = '0;
      tap_d = '0;
      oy_d  = '0;
      ox_d  = '0;
    end else begin
      if (tap_en) begin
        tap_d = last_tap ? '0 : tap_q + 1'b1;
        if (kx_q == KW'(K - 1)) begin
          kx_d = '0;
          if (ky_q == KW'(K - 1)) begin
            ky_d = '0;
            c_d  = (c_q == CHW'(CHIN - 1)) ? '0 : c_q + 1'b1;
          end else begin
            ky_d = ky_q + 1'b1;
          end
        end else begin
          kx_d = kx_q + 1'b1;
        end
      end
      if (win_en) begin
        if (ox_q == CW'(W_OUT - 1)) begin
          ox_d = '0;
          oy_d = (oy_q == RW'(H_OUT - 1)) ? '0 : oy_q + 1'b1;
        end else begin
          ox_d = ox_q + 1'b1;
        end
      end
    end
  end

  // Coordinates in the virtual padded frame; anything outside the real image reads as zero.
  always_comb begin
    y_i       = int'(oy_q) * STRIDE + int'(ky_q) - PAD;
    x_i       = int'(ox_q) * STRIDE + int'(kx_q) - PAD;
    in_bounds = (y_i >= 0) && (y_i < H_IN) && (x_i >= 0) && (x_i < W_IN);
    addr_i    = in_bounds ? (int'(c_q) * H_IN * W_IN + y_i * W_IN + x_i) : 0;
  end

  assign ifm_rd   = tap_en && in_bounds;
  assign ifm_addr = AW'(addr_i);
  assign w_addr   = tap_q;
  assign pad      = !in_bounds;
  assign oy       = oy_q;
  assign ox       = ox_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q   <= '0;
      ky_q  <= '0;
      kx_q  <= '0;
      tap_q <= '0;
      oy_q  <= '0;
      ox_q  <= '0;
    end else begin
      c_q   <= c_d;
      ky_q  <= ky_d;
      kx_q  <= kx_d;
      tap_q <= tap_d;
      oy_q  <= oy_d;
      ox_q  <= ox_d;
    end
  end

endmodule

// File: rtl/conv_engine.sv
// Single-layer convolution engine: one tap per cycle into CHOUT parallel accumulators,
// then bias, requantise, ReLU/saturate and hand one output vector per window downstream.
module conv_engine
  import conv_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FRAC   = 14,
  parameter int H_IN   = 256,
  parameter int W_IN   = 256,
  parameter int CHIN   = 3,
  parameter int CHOUT  = 64,
  parameter int K      = 3,
  parameter int STRIDE = 2,
  parameter int PAD    = 1,
  parameter int RELU   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  conv_engine_if.master bus
);

  localparam int TAPS  = K * K * CHIN;
  localparam int H_OUT = out_dim(H_IN, K, STRIDE, PAD);
  localparam int W_OUT = out_dim(W_IN, K, STRIDE, PAD);
  localparam int RW    = cw(H_OUT);
  localparam int CW    = cw(W_OUT);
  localparam int PW    = 2 * WIDTH;
  localparam int ACCW  = PW + cw(TAPS);
  localparam int SUMW  = ACCW + 1;

  state_e state_q, state_d;
  logic   drain_q, drain_d;
  logic   tap_en, win_en, clear, acc_clr, out_load;
  logic   pad_now, last_tap, last_window;
  logic [RW-1:0] oy;
  logic [CW-1:0] ox;

  logic                    v_q, v_d;
  logic                    pad_q, pad_d;
  logic signed [WIDTH-1:0] pixel;
  logic signed [WIDTH-1:0] w_q   [CHOUT];
  logic signed [WIDTH-1:0] w_d   [CHOUT];
  logic signed [ACCW-1:0]  acc_q [CHOUT];
  logic signed [ACCW-1:0]  acc_d [CHOUT];
  logic signed [WIDTH-1:0] ofm_q [CHOUT];
  logic signed [WIDTH-1:0] ofm_d [CHOUT];
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;

  conv_addr_gen #(
    .H_IN  (H_IN),
    .W_IN  (W_IN),
    .CHIN  (CHIN),
    .K     (K),
    .STRIDE(STRIDE),
    .PAD   (PAD)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .tap_en     (tap_en),
    .win_en     (win_en),
    .ifm_rd     (bus.ifm_rd),
    .ifm_addr   (bus.ifm_addr),
    .w_addr     (bus.w_addr),
    .pad        (pad_now),
    .last_tap   (last_tap),
    .last_window(last_window),
    .oy         (oy),
    .ox         (ox)
  );

  // DRAIN lasts two cycles so the final tap's product has landed before requantising.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    tap_en   = 1'b0;
    win_en   = 1'b0;
    clear    = 1'b0;
    acc_clr  = 1'b0;
    out_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
          acc_clr = 1'b1;
        end
      end
      RUN: begin
        tap_en = 1'b1;
        if (last_tap) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d  = OUT;
          out_load = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      OUT: begin
        if (bus.ofm_ready) begin
          win_en = 1'b1;
          if (last_window) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            acc_clr = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Weights and pad flag are delayed one cycle to line up with the sync-read pixel.
  always_comb begin
    v_d   = tap_en;
    pad_d = pad_now;
    pixel = pad_q ? '0 : $signed(bus.ifm_data);
    row_d = out_load ? oy : row_q;
    col_d = out_load ? ox : col_q;
  end

  for (genvar i = 0; i < CHOUT; i++) begin : g_lane
    logic signed [PW-1:0]    prod;
    logic signed [SUMW-1:0]  sum;
    logic signed [SUMW-1:0]  shifted;
    logic signed [WIDTH-1:0] res;

    always_comb begin
      w_d[i]   = $signed(bus.w_data[i]);
      prod     = PW'(pixel) * PW'(w_q[i]);
      sum      = SUMW'(acc_q[i]) + SUMW'($signed(bus.bias[i]));
      shifted  = sum >>> FRAC;
      res      = WIDTH'(sat_relu(64'(shifted), WIDTH, RELU != 0));
      acc_d[i] = acc_clr ? '0 : (v_q ? acc_q[i] + ACCW'(prod) : acc_q[i]);
      ofm_d[i] = out_load ? res : ofm_q[i];
    end

    assign bus.ofm[i] = ofm_q[i];
  end

  assign bus.ofm_valid = (state_q == OUT);
  assign bus.ofm_row   = row_q;
  assign bus.ofm_col   = col_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      v_q     <= 1'b0;
      pad_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      for (int i = 0; i < CHOUT; i++) begin
        w_q[i]   <= '0;
        acc_q[i] <= '0;
        ofm_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      v_q     <= v_d;
      pad_q   <= pad_d;
      row_q   <= row_d;
      col_q   <= col_d;
      for (int i = 0; i < CHOUT; i++) begin
        w_q[i]   <= w_d[i];
        acc_q[i] <= acc_d[i];
        ofm_q[i] <= ofm_d[i];
      end
    end
  end

endmodule

// File: tb/tb_conv_engine.sv
// Scoreboard bench for conv_engine: a padded stride-1 instance and an unpadded stride-2
// instance, checked against a plain-arithmetic convolution model.
module tb_conv_engine;
  import conv_pkg::*;

  localparam int WIDTH = 16;
  localparam int CHOUT = 2;

  typedef struct {
    int row;
    int col;
    int v0;
    int v1;
  } exp_t;

  logic clk;
  logic rst_n;
  logic start_a, start_b, busy_a, busy_b, done_a, done_b;

  conv_engine_if #(.WIDTH(WIDTH), .CHOUT(CHOUT), .AW(4), .WAW(4), .RW(2), .CW(2)) bus_a ();
  conv_engine_if #(.WIDTH(WIDTH), .CHOUT(CHOUT), .AW(5), .WAW(4), .RW(1), .CW(1)) bus_b ();

  conv_engine #(
    .WIDTH(WIDTH), .FRAC(14), .H_IN(4), .W_IN(4), .CHIN(1), .CHOUT(CHOUT),
    .K(3), .STRIDE(1), .PAD(1), .RELU(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a)
  );

  conv_engine #(
    .WIDTH(WIDTH), .FRAC(14), .H_IN(5), .W_IN(5), .CHIN(1), .CHOUT(CHOUT),
    .K(3), .STRIDE(2), .PAD(0), .RELU(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b)
  );

  logic signed [15:0] mem_a [16];
  logic signed [15:0] mem_b [25];
  logic signed [15:0] w_a [9][2];
  logic signed [15:0] w_b [9][2];
  logic signed [31:0] bias_a [2];
  logic signed [31:0] bias_b [2];

  exp_t q_a[$];
  exp_t q_b[$];
  int   errors = 0;
  int   checks = 0;
  int   accepted_a = 0;
  int   done_cnt_a = 0;
  int   done_cnt_b = 0;
  logic tr_rd [9];
  int   tr_addr [9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync-read IFM memories and combinational weight ROMs.
  always @(posedge clk) begin
    if (bus_a.ifm_rd) bus_a.ifm_data <= mem_a[bus_a.ifm_addr];
    if (bus_b.ifm_rd) bus_b.ifm_data <= mem_b[bus_b.ifm_addr];
  end

  always_comb begin
    bus_a.w_data = '0;
    bus_b.w_data = '0;
    bus_a.bias   = '0;
    bus_b.bias   = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (int'(bus_a.w_addr) < 9) bus_a.w_data[ch] = w_a[int'(bus_a.w_addr)][ch];
      if (int'(bus_b.w_addr) < 9) bus_b.w_data[ch] = w_b[int'(bus_b.w_addr)][ch];
      bus_a.bias[ch] = bias_a[ch];
      bus_b.bias[ch] = bias_b[ch];
    end
  end

  always @(posedge clk) begin
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Direct convolution over the padded frame, from the layer's arithmetic rules.
  function automatic int refOut(input int sel, input int oy, input int ox, input int ch);
    int     n, s, p;
    longint acc, pix, wt;
    n   = (sel == 0) ? 4 : 5;
    s   = (sel == 0) ? 1 : 2;
    p   = (sel == 0) ? 1 : 0;
    acc = 0;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        int y, x;
        y = oy * s + ky - p;
        x = ox * s + kx - p;
        if (y >= 0 && y < n && x >= 0 && x < n) begin
          pix = (sel == 0) ? longint'(mem_a[y * n + x]) : longint'(mem_b[y * n + x]);
          wt  = (sel == 0) ? longint'(w_a[ky * 3 + kx][ch]) : longint'(w_b[ky * 3 + kx][ch]);
          acc += pix * wt;
        end
      end
    end
    acc += (sel == 0) ? longint'(bias_a[ch]) : longint'(bias_b[ch]);
    acc = acc >>> 14;
    if (sel == 0 && acc < 0) acc = 0;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic pushFrame(input int sel);
    int   nout;
    exp_t e;
    nout = (sel == 0) ? 4 : 2;
    for (int oy = 0; oy < nout; oy++) begin
      for (int ox = 0; ox < nout; ox++) begin
        e.row = oy;
        e.col = ox;
        e.v0  = refOut(sel, oy, ox, 0);
        e.v1  = refOut(sel, oy, ox, 1);
        if (sel == 0) q_a.push_back(e);
        else q_b.push_back(e);
      end
    end
  endtask

  // Monitors: compare each accepted vector against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus_a.ofm_valid && bus_a.ofm_ready) begin
      accepted_a++;
      if (q_a.size() == 0) begin
        checkOutput("a_unexpected_vector", 1, 0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        checkOutput("a_row", int'(bus_a.ofm_row), e.row);
        checkOutput("a_col", int'(bus_a.ofm_col), e.col);
        checkOutput("a_ofm0", int'($signed(bus_a.ofm[0])), e.v0);
        checkOutput("a_ofm1", int'($signed(bus_a.ofm[1])), e.v1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_b.ofm_valid && bus_b.ofm_ready) begin
      if (q_b.size() == 0) begin
        checkOutput("b_unexpected_vector", 1, 0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        checkOutput("b_row", int'(bus_b.ofm_row), e.row);
        checkOutput("b_col", int'(bus_b.ofm_col), e.col);
        checkOutput("b_ofm0", int'($signed(bus_b.ofm[0])), e.v0);
        checkOutput("b_ofm1", int'($signed(bus_b.ofm[1])), e.v1);
      end
    end
  end

  task automatic fillA(input int pix, input int wt, input int bias);
    for (int i = 0; i < 16; i++) mem_a[i] = 16'(pix);
    for (int t = 0; t < 9; t++) for (int ch = 0; ch < 2; ch++) w_a[t][ch] = 16'(wt);
    for (int ch = 0; ch < 2; ch++) bias_a[ch] = 32'(bias);
  endtask

  task automatic fillRand(input int sel);
    for (int i = 0; i < 25; i++) begin
      if (sel == 0 && i < 16) mem_a[i] = 16'(int'($urandom_range(0, 32767)) - 16384);
      if (sel == 1) mem_b[i] = 16'(int'($urandom_range(0, 32767)) - 16384);
    end
    for (int t = 0; t < 9; t++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (sel == 0) w_a[t][ch] = 16'(int'($urandom_range(0, 32767)) - 16384);
        else w_b[t][ch] = 16'(int'($urandom_range(0, 32767)) - 16384);
      end
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (sel == 0) bias_a[ch] = 32'(int'($urandom_range(0, 1 << 28)) - (1 << 27));
      else bias_b[ch] = 32'(int'($urandom_range(0, 1 << 28)) - (1 << 27));
    end
  endtask

  // One frame: queue expectations, pulse start, record the first window's taps, wait for done.
  task automatic applyStimulus(input int sel, input bit check_lat, input bit extra_start);
    int cyc, done_before, exp_lat;
    pushFrame(sel);
    done_before = (sel == 0) ? done_cnt_a : done_cnt_b;
    exp_lat     = (sel == 0) ? 16 * (9 + 3) : 4 * (9 + 3);
    @(posedge clk);
    #1;
    if (sel == 0) start_a = 1'b1;
    else start_b = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (cyc < 9) begin
        tr_rd[cyc]   = (sel == 0) ? bus_a.ifm_rd : bus_b.ifm_rd;
        tr_addr[cyc] = (sel == 0) ? int'(bus_a.ifm_addr) : int'(bus_b.ifm_addr);
      end
      if (extra_start && cyc == 40) start_a = 1'b1;
      if (extra_start && cyc == 41) start_a = 1'b0;
      if ((sel == 0) ? done_a : done_b) break;
      if (cyc > 4000) begin
        checkOutput("done_timeout", cyc, exp_lat);
        break;
      end
      @(posedge clk);
      cyc++;
    end
    if (check_lat) checkOutput("frame_latency", cyc, exp_lat);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_pulses", ((sel == 0) ? done_cnt_a : done_cnt_b) - done_before, 1);
    checkOutput("queue_drained", (sel == 0) ? q_a.size() : q_b.size(), 0);
    checkOutput("busy_after_frame", int'((sel == 0) ? busy_a : busy_b), 0);
  endtask

  task automatic stallAtWindow5();
    int   base, n;
    logic [15:0] h0, h1;
    logic [1:0]  hr, hc;
    base = accepted_a;
    n    = 0;
    while (accepted_a - base < 5 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1 bus_a.ofm_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.ofm_valid && n < 100);
    checkOutput("stall_valid_seen", int'(bus_a.ofm_valid), 1);
    h0 = bus_a.ofm[0];
    h1 = bus_a.ofm[1];
    hr = bus_a.ofm_row;
    hc = bus_a.ofm_col;
    checkOutput("stall_row", int'(hr), 1);
    checkOutput("stall_col", int'(hc), 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("stall_valid", int'(bus_a.ofm_valid), 1);
      checkOutput("stall_ifm_rd", int'(bus_a.ifm_rd), 0);
      checkOutput("stall_ofm0", int'(bus_a.ofm[0]), int'(h0));
      checkOutput("stall_ofm1", int'(bus_a.ofm[1]), int'(h1));
      checkOutput("stall_rowcol", int'({bus_a.ofm_row, bus_a.ofm_col}), int'({hr, hc}));
    end
    bus_a.ofm_ready = 1'b1;
  endtask

  task automatic jitterReady(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 bus_a.ofm_ready = ($urandom_range(0, 3) != 0);
    end
    bus_a.ofm_ready = 1'b1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, int'(busy_a), 0);
    checkOutput({tag, "_done"}, int'(done_a), 0);
    checkOutput({tag, "_ifm_rd"}, int'(bus_a.ifm_rd), 0);
    checkOutput({tag, "_valid"}, int'(bus_a.ofm_valid), 0);
    checkOutput({tag, "_ofm"}, int'(bus_a.ofm), 0);
    checkOutput({tag, "_rowcol"}, int'({bus_a.ofm_row, bus_a.ofm_col}), 0);
  endtask

  initial begin
    int exp_rd [9];
    int exp_ab [9];
    exp_rd = '{0, 0, 0, 0, 1, 1, 0, 1, 1};
    exp_ab = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bus_a.ofm_ready = 1'b1;
    bus_b.ofm_ready = 1'b1;
    fillA(4096, 8192, 0);
    fillRand(1);
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    checkOutput("reset_b_busy", int'(busy_b), 0);
    rst_n = 1'b1;

    $display("[TB] uniform frame, latency and pad pattern");
    applyStimulus(0, 1'b1, 1'b0);
    for (int t = 0; t < 9; t++) begin
      checkOutput($sformatf("pad_rd_tap%0d", t), int'(tr_rd[t]), exp_rd[t]);
    end
    checkOutput("addr_tap4", tr_addr[4], 0);
    checkOutput("addr_tap5", tr_addr[5], 1);
    checkOutput("addr_tap7", tr_addr[7], 4);
    checkOutput("addr_tap8", tr_addr[8], 5);

    $display("[TB] saturation and relu frames");
    fillA(16384, 16384, 0);
    applyStimulus(0, 1'b1, 1'b0);
    fillA(16384, -8192, 0);
    applyStimulus(0, 1'b1, 1'b0);

    $display("[TB] random frames with jittered ready");
    for (int f = 0; f < 3; f++) begin
      fillRand(0);
      fork
        applyStimulus(0, 1'b0, 1'b0);
        jitterReady(150);
      join
    end

    $display("[TB] back-pressure at window 5");
    fillA(4096, 8192, 0);
    fork
      applyStimulus(0, 1'b0, 1'b0);
      stallAtWindow5();
    join

    $display("[TB] stride-2 unpadded instance");
    for (int f = 0; f < 2; f++) begin
      fillRand(1);
      applyStimulus(1, 1'b1, 1'b0);
      for (int t = 0; t < 9; t++) begin
        checkOutput($sformatf("b_rd_tap%0d", t), int'(tr_rd[t]), 1);
        checkOutput($sformatf("b_addr_tap%0d", t), tr_addr[t], exp_ab[t]);
      end
    end

    $display("[TB] reset mid-frame, ignored start, restart");
    fillA(4096, 8192, 0);
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkIdleOutputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
